// File: rtl/tdm_pkg.sv
// tdm_pkg: shared FSM states and frame sizing for tdm_demux.
// TDM_DEMUX_PARITY_EN adds one trailing XOR parity slot per frame.
package tdm_pkg;
  typedef enum logic {HUNT, LOCK} state_t;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int EXTRA_SLOTS = 1;
`else
  localparam int EXTRA_SLOTS = 0;
`endif
  function automatic int frame_len(input int n_ch);
    return n_ch + EXTRA_SLOTS;
  endfunction
  function automatic int slot_w(input int len);
    return (len > 2) ? $clog2(len) : 1;
  endfunction
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: wrapping slot counter with load-to-1 on frame sync.
module tdm_slot_counter #(
  parameter int LEN = 4,
  parameter int SW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_load,
  output logic [SW-1:0] o_slot,
  output logic          o_tc
);
  assign o_tc = o_slot == SW'(LEN - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) o_slot <= '0;
    else if (i_en) o_slot <= i_load ? SW'(1) : o_tc ? '0 : o_slot + SW'(1);
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: splits a round-robin TDM sample stream into per-channel registers.
// TDM_DEMUX_PARITY_EN appends a checked XOR parity slot and a parity_err pulse.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    in_data,
  input  logic            in_valid,
  input  logic            frame_sync,
  output logic [N_CH*W-1:0] out_data,
  output logic [N_CH-1:0] out_valid,
  output logic            frame_done,
  output logic            sync_err,
`ifdef TDM_DEMUX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            locked
);
  localparam int LEN = frame_len(N_CH);
  localparam int SW  = slot_w(LEN);
  state_t r_state, w_next;
  logic [SW-1:0] w_slot, w_ch;
  logic w_tc, w_lock, w_accept, w_misalign, w_par_slot, w_wr, w_done;
  logic [N_CH*W-1:0] r_data;
  logic [N_CH-1:0] r_valid;
  logic r_done, r_err;
  assign w_lock     = r_state == LOCK;
  assign w_accept   = in_valid & (w_lock | frame_sync);
  assign w_misalign = in_valid & w_lock & frame_sync & (w_slot != '0);
  assign w_ch       = frame_sync ? '0 : w_slot;
  assign w_done     = in_valid & w_lock & ~frame_sync & w_tc;
`ifdef TDM_DEMUX_PARITY_EN
  assign w_par_slot = w_lock & ~frame_sync & (w_slot == SW'(N_CH));
`else
  assign w_par_slot = 1'b0;
`endif
  assign w_wr = w_accept & ~w_par_slot;
  tdm_slot_counter #(.LEN(LEN), .SW(SW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_accept),
    .i_load(frame_sync),
    .o_slot(w_slot),
    .o_tc  (w_tc)
  );
  always_comb begin
    w_next = r_state;
    if (in_valid & frame_sync) w_next = LOCK;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HUNT;
      r_data  <= '0;
      r_valid <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= w_wr ? (N_CH'(1) << w_ch) : '0;
      r_done  <= w_done;
      r_err   <= w_misalign;
      if (w_wr) r_data[int'(w_ch)*W +: W] <= in_data;
    end
  end
`ifdef TDM_DEMUX_PARITY_EN
  logic [W-1:0] r_acc;
  logic r_perr;
  // Channel 0 restarts the running XOR so a resync discards the partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_perr <= 1'b0;
    end else begin
      r_perr <= w_done & (in_data != r_acc);
      if (w_wr) r_acc <= (w_ch == '0) ? in_data : r_acc ^ in_data;
    end
  end
  assign parity_err = r_perr;
`endif
  assign out_data   = r_data;
  assign out_valid  = r_valid;
  assign frame_done = r_done;
  assign sync_err   = r_err;
  assign locked     = w_lock;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed plus randomized checks of tdm_demux against a frame-level model.
module tb_tdm_demux;
  localparam int N = 4;
  localparam int W = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int LEN = N + 1;
`else
  localparam int LEN = N;
`endif
  logic clk = 0, rst = 0;
  logic [W-1:0] in_data = '0;
  logic in_valid = 0, frame_sync = 0;
  logic [N*W-1:0] out_data;
  logic [N-1:0] out_valid;
  logic frame_done, sync_err, locked, parity_err;
  int checks = 0, failures = 0;
  bit m_lock;
  int m_slot;
  logic [W-1:0] m_ch [N];
  logic [W-1:0] m_acc;
  logic [N-1:0] e_valid;
  logic e_done, e_err, e_perr;
  tdm_demux #(.N_CH(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .frame_sync(frame_sync),
    .out_data  (out_data),
    .out_valid (out_valid),
    .frame_done(frame_done),
    .sync_err  (sync_err),
`ifdef TDM_DEMUX_PARITY_EN
    .parity_err(parity_err),
`endif
    .locked    (locked)
  );
`ifndef TDM_DEMUX_PARITY_EN
  assign parity_err = 1'b0;
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [N*W-1:0] m_pack();
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = m_ch[k];
    return r;
  endfunction
  task automatic check_all(input string tag);
    chk({tag, ".data"}, out_data, m_pack());
    chk({tag, ".valid"}, out_valid, e_valid);
    chk({tag, ".done"}, frame_done, e_done);
    chk({tag, ".sync_err"}, sync_err, e_err);
    chk({tag, ".locked"}, locked, m_lock);
    chk({tag, ".parity_err"}, parity_err, e_perr);
    chk({tag, ".onehot"}, $countones(out_valid) <= 1, 1);
  endtask
  task automatic model_reset();
    m_lock = 0;
    m_slot = 0;
    m_acc = '0;
    for (int k = 0; k < N; k++) m_ch[k] = '0;
    e_valid = '0;
    e_done = 0;
    e_err = 0;
    e_perr = 0;
  endtask
  task automatic wr(input int k, input logic [W-1:0] d);
    m_ch[k] = d;
    e_valid[k] = 1'b1;
    m_acc = (k == 0) ? d : (m_acc ^ d);
  endtask
  task automatic step(input string tag, input logic v, input logic s, input logic [W-1:0] d);
    in_valid = v;
    frame_sync = s;
    in_data = d;
    e_valid = '0;
    e_done = 0;
    e_err = 0;
    e_perr = 0;
    if (v) begin
      if (s) begin
        e_err = m_lock && m_slot != 0;
        m_lock = 1;
        wr(0, d);
        m_slot = 1;
      end else if (m_lock) begin
        if (m_slot < N) begin
          wr(m_slot, d);
          e_done = (m_slot == LEN - 1);
        end else begin
          e_perr = (d != m_acc);
          e_done = 1;
        end
        m_slot = (m_slot + 1) % LEN;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask
  task automatic do_reset();
    #2;
    rst = 1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #2;
    rst = 0;
    #1;
    check_all("rst_release");
  endtask
  task automatic send_parity(input string tag, input logic [W-1:0] p);
`ifdef TDM_DEMUX_PARITY_EN
    step(tag, 1, 0, p);
`endif
  endtask
  initial begin
    model_reset();
    #1 rst = 1;
    #2 check_all("reset");
    #9 rst = 0;
    step("clean", 1, 1, 8'hA0);
    chk("clean.locked_rise", locked, 1);
    step("clean", 1, 0, 8'hB1);
    step("clean", 1, 0, 8'hC2);
    step("clean", 1, 0, 8'hD3);
    chk("clean.frame", out_data, 32'hD3C2B1A0);
    send_parity("clean.par", 8'hA0 ^ 8'hB1 ^ 8'hC2 ^ 8'hD3);
    do_reset();
    step("hunt", 1, 0, 8'h11);
    step("hunt", 1, 0, 8'h22);
    step("hunt", 1, 1, 8'h33);
    chk("hunt.ch0", out_data[7:0], 8'h33);
    step("hunt", 1, 0, 8'h44);
    step("hunt", 1, 0, 8'h55);
    step("hunt", 1, 0, 8'h66);
    send_parity("hunt.par", 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66);
    step("stall", 1, 1, 8'h10);
    step("stall", 1, 0, 8'h20);
    for (int i = 0; i < 3; i++) step("stall.idle", 0, 1, 8'hEE);
    step("stall", 1, 0, 8'h30);
    step("stall", 1, 0, 8'h40);
    chk("stall.done", frame_done, 1);
    send_parity("stall.par", 8'h10 ^ 8'h20 ^ 8'h30 ^ 8'h40);
    step("mis", 1, 1, 8'h51);
    step("mis", 1, 0, 8'h62);
    step("mis", 1, 1, 8'h77);
    chk("mis.sync_err", sync_err, 1);
    chk("mis.ch0", out_data[7:0], 8'h77);
    step("mis", 1, 0, 8'h88);
    step("mis", 1, 0, 8'h99);
    step("mis", 1, 0, 8'hAA);
    send_parity("mis.par", 8'h77 ^ 8'h88 ^ 8'h99 ^ 8'hAA);
`ifdef TDM_DEMUX_PARITY_EN
    step("par_ok", 1, 1, 8'h01);
    step("par_ok", 1, 0, 8'h02);
    step("par_ok", 1, 0, 8'h04);
    step("par_ok", 1, 0, 8'h08);
    step("par_ok", 1, 0, 8'h0F);
    chk("par_ok.perr", parity_err, 0);
    step("par_bad", 1, 1, 8'h01);
    step("par_bad", 1, 0, 8'h02);
    step("par_bad", 1, 0, 8'h04);
    step("par_bad", 1, 0, 8'h08);
    step("par_bad", 1, 0, 8'h0E);
    chk("par_bad.perr", parity_err, 1);
    chk("par_bad.done", frame_done, 1);
`endif
    step("midrst", 1, 1, 8'h5A);
    step("midrst", 1, 0, 8'h6B);
    do_reset();
    chk("midrst.data", out_data, 0);
    step("midrst", 1, 0, 8'h99);
    chk("midrst.locked", locked, 0);
    for (int i = 0; i < 3000; i++) begin
      logic v, s;
      if ($urandom_range(0, 399) == 0) do_reset();
      v = ($urandom_range(0, 3) != 0);
      s = v && ((m_slot == 0 && $urandom_range(0, 7) != 0) || $urandom_range(0, 19) == 0);
      step("rand", v, s, W'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
